// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-lite to APB bridge: transfer types, responses
// and the bridge FSM states.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // NONSEQ and SEQ are the only transfer types that move data.
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps an AHB address onto a one-hot APB slave select; addresses below the
// window base or past the last slave region raise the miss flag.
module apb_addr_decoder
  import ahb_apb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
  parameter int unsigned       REGION_BITS = 10
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               miss
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    sel  = '0;
    off  = addr - BASE_ADDR;
    idx  = off >> REGION_BITS;
    miss = (addr < BASE_ADDR) || (idx >= ADDR_W'(NUM_SLV));
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      sel[i] = !miss && (idx == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-lite to APB bridge for NUM_SLV slaves: one transfer at a time, with
// Pready wait states, slave/decode error responses and a wait-state timeout.
module ahb_apb_bridge_mslv
  import ahb_apb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
  parameter int unsigned       REGION_BITS = 10,
  parameter int unsigned       MAX_WAIT    = 16
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic [1:0]         Htrans,
  input  logic               Hwrite,
  input  logic               Hreadyin,
  input  logic [ADDR_W-1:0]  Haddr,
  input  logic [DATA_W-1:0]  Hwdata,
  output logic               Hreadyout,
  output logic [1:0]         Hresp,
  output logic [DATA_W-1:0]  Hrdata,
  output logic [NUM_SLV-1:0] Pselx,
  output logic               Penable,
  output logic               Pwrite,
  output logic [ADDR_W-1:0]  Paddr,
  output logic [DATA_W-1:0]  Pwdata,
  input  logic [DATA_W-1:0]  Prdata,
  input  logic               Pready,
  input  logic               Pslverr
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  state_e             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [NUM_SLV-1:0] sel_q;
  logic               miss_q;
  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_miss;
  logic               valid;

  apb_addr_decoder #(
    .ADDR_W      (ADDR_W),
    .NUM_SLV     (NUM_SLV),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS)
  ) u_dec (
    .addr (Haddr),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  always_comb begin
    valid   = htrans_active(Htrans) && Hreadyin && Hreadyout;
    state_n = state;
    cnt_n   = '0;
    case (state)
      ST_IDLE, ST_DONE: state_n = valid ? ST_LATCH : ST_IDLE;
      ST_LATCH:         state_n = miss_q ? ST_ERR1 : ST_SETUP;
      ST_SETUP:         state_n = ST_ACCESS;
      ST_ACCESS: begin
        if (Pready) begin
          state_n = Pslverr ? ST_ERR1 : ST_DONE;
        end else if (cnt == CW'(MAX_WAIT - 1)) begin
          state_n = ST_ERR1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_ERR1:          state_n = ST_ERR2;
      ST_ERR2:          state_n = ST_IDLE;
      default:          state_n = ST_IDLE;
    endcase
  end

  // Every output is registered from the next state so it lines up with the
  // state it belongs to rather than lagging by a cycle.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      Hreadyout <= 1'b1;
      Hresp     <= HRESP_OKAY;
      Hrdata    <= '0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      miss_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      Hreadyout <= (state_n == ST_IDLE) || (state_n == ST_DONE) || (state_n == ST_ERR2);
      Hresp     <= ((state_n == ST_ERR1) || (state_n == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      Penable   <= (state_n == ST_ACCESS);
      Pselx     <= ((state_n == ST_SETUP) || (state_n == ST_ACCESS)) ? sel_q : '0;
      if (((state == ST_IDLE) || (state == ST_DONE)) && valid) begin
        addr_q  <= Haddr;
        write_q <= Hwrite;
        sel_q   <= dec_sel;
        miss_q  <= dec_miss;
      end
      if ((state == ST_LATCH) && !miss_q) begin
        Paddr  <= addr_q;
        Pwrite <= write_q;
        Pwdata <= Hwdata;
      end
      if ((state == ST_ACCESS) && Pready && !Pslverr && !Pwrite) begin
        Hrdata <= Prdata;
      end
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Directed bench for ahb_apb_bridge_mslv: latency, selects, wait states,
// error responses, timeout and reset behaviour against hand-derived values.
module tb_ahb_apb_bridge_mslv;
  import ahb_apb_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hreset, Hwrite, Hreadyin, Hreadyout;
  logic [1:0]  Htrans, Hresp;
  logic [31:0] Haddr, Hwdata, Hrdata, Paddr, Pwdata, Prdata;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite, Pready, Pslverr;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  int unsigned r_lat, r_setup, r_pen, r_acc;
  logic [2:0]  r_sel;
  logic [31:0] r_paddr, r_pwdata;
  logic        r_pwrite, r_rdy_prev, r_rdy_after;
  logic [1:0]  r_resp_prev, r_resp, r_resp_after;

  always #5 Hclk = ~Hclk;

  ahb_apb_bridge_mslv #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .NUM_SLV     (3),
    .BASE_ADDR   (32'h8000_0000),
    .REGION_BITS (10),
    .MAX_WAIT    (16)
  ) dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .Htrans    (Htrans),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata),
    .Pready    (Pready),
    .Pslverr   (Pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Hclk);
    #1;
  endtask

  // One AHB transfer; Pready is held low for the first 'lows' ACCESS cycles.
  // r_lat counts cycles from the address phase to Hreadyout=1.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input int unsigned lows, input logic err);
    Haddr  = addr;
    Hwrite = wr;
    Htrans = HTRANS_NONSEQ;
    r_setup = 0; r_pen = 0; r_acc = 0; r_sel = '0;
    r_paddr = '0; r_pwdata = '0; r_pwrite = 1'b0;
    r_resp_prev = 2'b11; r_rdy_prev = 1'b1;
    tick;
    Htrans  = HTRANS_IDLE;
    Hwdata  = wdata;
    Pready  = (lows == 0);
    Pslverr = err;
    r_lat   = 1;
    while (Hreadyout !== 1'b1 && r_lat < 60) begin
      r_resp_prev = Hresp;
      r_rdy_prev  = Hreadyout;
      tick;
      r_lat++;
      r_sel |= Pselx;
      if (Pselx != 3'b000 && !Penable && r_setup == 0) begin
        r_setup  = r_lat;
        r_paddr  = Paddr;
        r_pwdata = Pwdata;
        r_pwrite = Pwrite;
      end
      if (Penable) begin
        if (r_pen == 0) r_pen = r_lat;
        r_acc++;
        Pready = (r_acc > lows);
      end
    end
    r_resp  = Hresp;
    Pready  = 1'b1;
    Pslverr = 1'b0;
    tick;
    r_resp_after = Hresp;
    r_rdy_after  = Hreadyout;
  endtask

  initial begin
    logic [2:0] seen_sel;
    logic       seen_pen;
    int unsigned k;

    Hreset = 1'b1; Htrans = HTRANS_IDLE; Hwrite = 1'b0; Hreadyin = 1'b1;
    Haddr = '0; Hwdata = '0; Prdata = '0; Pready = 1'b1; Pslverr = 1'b0;
    tick; tick;
    chk("rst_hreadyout", 32'(Hreadyout), 32'd1);
    chk("rst_hresp",     32'(Hresp),     32'd0);
    chk("rst_hrdata",    Hrdata,         32'h0);
    chk("rst_pselx",     32'(Pselx),     32'd0);
    chk("rst_penable",   32'(Penable),   32'd0);
    chk("rst_pwrite",    32'(Pwrite),    32'd0);
    chk("rst_paddr",     Paddr,          32'h0);
    chk("rst_pwdata",    Pwdata,         32'h0);
    Hreset = 1'b0;
    tick;

    // BUSY transfers are ignored
    Htrans = HTRANS_BUSY; Haddr = 32'h8000_0000;
    seen_sel = '0;
    repeat (3) begin tick; seen_sel |= Pselx; end
    chk("busy_ready", 32'(Hreadyout), 32'd1);
    chk("busy_sel",   32'(seen_sel),  32'd0);
    Htrans = HTRANS_IDLE;
    tick;

    // 1: zero-wait write to slave 1
    xfer(32'h8000_0400, 1'b1, 32'hA5A5_0001, 0, 1'b0);
    chk("t1_lat",    r_lat,          32'd4);
    chk("t1_setup",  r_setup,        32'd2);
    chk("t1_pen",    r_pen,          32'd3);
    chk("t1_sel",    32'(r_sel),     32'b010);
    chk("t1_paddr",  r_paddr,        32'h8000_0400);
    chk("t1_pwdata", r_pwdata,       32'hA5A5_0001);
    chk("t1_pwrite", 32'(r_pwrite),  32'd1);
    chk("t1_resp",   32'(r_resp),    32'd0);

    // 2: read slave 0 with three wait states
    Prdata = 32'h1234_5678;
    xfer(32'h8000_0000, 1'b0, 32'h0, 3, 1'b0);
    chk("t2_lat",    r_lat,          32'd7);
    chk("t2_sel",    32'(r_sel),     32'b001);
    chk("t2_pwrite", 32'(r_pwrite),  32'd0);
    chk("t2_hrdata", Hrdata,         32'h1234_5678);
    chk("t2_resp",   32'(r_resp),    32'd0);

    // 3: decode miss past last slave, then below the window
    xfer(32'h8000_0C00, 1'b1, 32'hFFFF_0000, 0, 1'b0);
    chk("t3_sel",       32'(r_sel),        32'd0);
    chk("t3_lat",       r_lat,             32'd3);
    chk("t3_err1_resp", 32'(r_resp_prev),  32'd1);
    chk("t3_err1_rdy",  32'(r_rdy_prev),   32'd0);
    chk("t3_err2_resp", 32'(r_resp),       32'd1);
    chk("t3_idle_resp", 32'(r_resp_after), 32'd0);
    chk("t3_paddr_hold", Paddr,            32'h8000_0000);
    xfer(32'h7FFF_FFFC, 1'b0, 32'h0, 0, 1'b0);
    chk("t3b_sel",  32'(r_sel),  32'd0);
    chk("t3b_lat",  r_lat,       32'd3);
    chk("t3b_resp", 32'(r_resp), 32'd1);

    // last word of slave 2 still decodes
    Prdata = 32'h0BAD_CAFE;
    xfer(32'h8000_0BFC, 1'b0, 32'h0, 0, 1'b0);
    chk("edge_sel",    32'(r_sel), 32'b100);
    chk("edge_lat",    r_lat,      32'd4);
    chk("edge_hrdata", Hrdata,     32'h0BAD_CAFE);

    // 4: slave error on read
    Prdata = 32'hDEAD_BEEF;
    xfer(32'h8000_0400, 1'b0, 32'h0, 0, 1'b1);
    chk("t4_lat",       r_lat,            32'd5);
    chk("t4_sel",       32'(r_sel),       32'b010);
    chk("t4_err1_resp", 32'(r_resp_prev), 32'd1);
    chk("t4_err2_resp", 32'(r_resp),      32'd1);
    chk("t4_hrdata",    Hrdata,           32'h0BAD_CAFE);
    chk("t4_after_rdy", 32'(r_rdy_after), 32'd1);

    // 5: wait-state timeout, then a normal write
    xfer(32'h8000_0800, 1'b0, 32'h0, 100, 1'b0);
    chk("t5_acc",   r_acc,           32'd16);
    chk("t5_lat",   r_lat,           32'd20);
    chk("t5_sel",   32'(r_sel),      32'b100);
    chk("t5_resp",  32'(r_resp),     32'd1);
    chk("t5_pselx", 32'(Pselx),      32'd0);
    xfer(32'h8000_0010, 1'b1, 32'h0000_5A5A, 0, 1'b0);
    chk("t5b_lat",    r_lat,      32'd4);
    chk("t5b_sel",    32'(r_sel), 32'b001);
    chk("t5b_paddr",  r_paddr,    32'h8000_0010);
    chk("t5b_pwdata", r_pwdata,   32'h0000_5A5A);
    chk("t5b_resp",   32'(r_resp), 32'd0);

    // 6: reset during ACCESS
    Haddr = 32'h8000_0800; Hwrite = 1'b1; Htrans = HTRANS_NONSEQ;
    tick;
    Htrans = HTRANS_IDLE; Hwdata = 32'h1; Pready = 1'b0;
    k = 0;
    while (Penable !== 1'b1 && k < 10) begin tick; k++; end
    chk("t6_access_reached", 32'(Penable), 32'd1);
    Hreset = 1'b1;
    tick;
    chk("t6_pselx",  32'(Pselx),     32'd0);
    chk("t6_penable", 32'(Penable),  32'd0);
    chk("t6_ready",  32'(Hreadyout), 32'd1);
    chk("t6_resp",   32'(Hresp),     32'd0);
    chk("t6_hrdata", Hrdata,         32'h0);
    Hreset = 1'b0; Pready = 1'b1; Htrans = HTRANS_BUSY;
    seen_sel = '0; seen_pen = 1'b0;
    repeat (5) begin tick; seen_sel |= Pselx; seen_pen |= Penable; end
    chk("t6_busy_sel",   32'(seen_sel),  32'd0);
    chk("t6_busy_pen",   32'(seen_pen),  32'd0);
    chk("t6_busy_ready", 32'(Hreadyout), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
